// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared_reg_arbiter slice.
// Holds the arbiter state encoding and the round-robin winner search.
package shared_reg_arbiter_pkg;

    // Upper bound on requesters; the pick helper works on vectors this wide.
    localparam int MAX_NREQ = 8;
    localparam int PICK_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First requester at or after ptr, wrapping at nreq back to 0.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [PICK_W-1:0]   ptr,
                                      input int                  nreq);
        pick_t p;
        int    idx;
        p = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (i < nreq && !p.valid && req[idx[PICK_W-1:0]]) begin
                p.valid = 1'b1;
                p.idx   = idx[PICK_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/shared_reg_bank.sv
// Shared WIDTH-bit state register written by whichever requester owns it.
module shared_reg_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load new data only on an enabled cycle, otherwise keep the contents.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Storage flop, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared enabled state register.
// A granted requester may write the register every cycle it holds the grant;
// ownership ends on release or on timeout preemption when others wait.
// Optional macro SHARED_REG_ARB_FIXED_PRIO_EN: requester 0 always wins IDLE
// arbitration when requesting and is never timeout-preempted.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           wr,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner_id,
    output logic                      busy,
    output logic                      reg_en,
    output logic [WIDTH-1:0]          q
);

    localparam int IDW    = $clog2(NREQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;

    logic [MAX_NREQ-1:0] req_ext;
    pick_t               pick;
    logic                others_waiting;
    logic                preempt_ok;

    // Next-state, grant, pointer and hold-counter computation for the arbiter FSM.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        hold_d         = hold_q;
        req_ext        = '0;
        req_ext[NREQ-1:0] = req;
        pick           = rr_pick(req_ext, PICK_W'(ptr_q), NREQ);
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            pick.valid = 1'b1;
            pick.idx   = '0;
        end
        preempt_ok     = (owner_q != '0);
`else
        preempt_ok     = 1'b1;
`endif
        others_waiting = |(req & ~gnt_q);

        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    state_d = GRANT;
                    owner_d = IDW'(pick.idx);
                    gnt_d   = NREQ'(1) << pick.idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if (!req[owner_q] ||
                    (hold_q == HOLD_LAST && others_waiting && preempt_ok)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    if (int'(owner_q) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = owner_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Arbiter FSM registers; reset aborts any grant at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    // Only the current owner, still requesting, may write this cycle.
    always_comb begin
        reg_en = (state_q == GRANT) && req[owner_q] && wr[owner_q];
    end

    shared_reg_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .en  (reg_en),
        .d   (wdata[owner_q*WIDTH +: WIDTH]),
        .q   (q)
    );

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter with hand-computed directed vectors.
// Each vector pushes the outputs expected after its clock edge; the monitor
// pops and compares one entry per edge. reg_en is sampled just before the edge.
module tb_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       wr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner_id;
    logic                  busy;
    logic                  reg_en;
    logic [WIDTH-1:0]      q;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic [3:0] q;
        logic       en;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    logic en_pre;

    shared_reg_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner_id (owner_id),
        .busy     (busy),
        .reg_en   (reg_en),
        .q        (q)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] w,
                                 input logic [15:0] wd, input logic [3:0] eg,
                                 input logic [1:0] eo, input logic eb,
                                 input logic [3:0] eq, input logic ee);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req   = rq;
        wr    = w;
        wdata = wd;
        e.gnt   = eg;
        e.owner = eo;
        e.busy  = eb;
        e.q     = eq;
        e.en    = ee;
        sb.push_back(e);
    endtask

    // Monitor: sample reg_en before the edge, then compare registered outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            en_pre = reg_en;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("gnt", 32'(gnt), 32'(e.gnt));
                checkOutput("owner_id", 32'(owner_id), 32'(e.owner));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("q", 32'(q), 32'(e.q));
                if (e.en !== 1'bx) begin
                    checkOutput("reg_en", 32'(en_pre), 32'(e.en));
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst   = 1'b1;
        req   = '0;
        wr    = '0;
        wdata = '0;

        // Reset
        applyStimulus(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'h0, 1'bx);
        applyStimulus(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'h0, 0);

        // Single requester 0 writes 4'hA
        applyStimulus(0, 4'b0001, 4'b0001, 16'h000A, 4'b0001, 2'd0, 1, 4'h0, 0);
        applyStimulus(0, 4'b0001, 4'b0001, 16'h000A, 4'b0001, 2'd0, 1, 4'hA, 1);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 1, 4'hA, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'hA, 0);

        // Simultaneous 1 and 3; non-owner write from 3 ignored; handover to 3
        applyStimulus(0, 4'b1010, 4'b0000, 16'h0000, 4'b0010, 2'd1, 1, 4'hA, 0);
        applyStimulus(0, 4'b1010, 4'b1000, 16'h5000, 4'b0010, 2'd1, 1, 4'hA, 0);
        applyStimulus(0, 4'b1000, 4'b0000, 16'h0000, 4'b0000, 2'd1, 1, 4'hA, 0);
        applyStimulus(0, 4'b1000, 4'b0000, 16'h0000, 4'b0000, 2'd1, 0, 4'hA, 0);
        applyStimulus(0, 4'b1000, 4'b0000, 16'h0000, 4'b1000, 2'd3, 1, 4'hA, 0);
        applyStimulus(0, 4'b1000, 4'b1000, 16'h7000, 4'b1000, 2'd3, 1, 4'h7, 1);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd3, 1, 4'h7, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd3, 0, 4'h7, 0);

        // Requester 2 granted, requester 0 joins on grant cycle 5, preempted after 8 cycles
        applyStimulus(0, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 2'd2, 1, 4'h7, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 2'd2, 1, 4'h7, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 4'b0101, 4'b0000, 16'h0000, 4'b0100, 2'd2, 1, 4'h7, 0);
        applyStimulus(0, 4'b0101, 4'b0100, 16'h0300, 4'b0000, 2'd2, 1, 4'h3, 1);
        applyStimulus(0, 4'b0001, 4'b0000, 16'h0000, 4'b0000, 2'd2, 0, 4'h3, 0);
        applyStimulus(0, 4'b0001, 4'b0000, 16'h0000, 4'b0001, 2'd0, 1, 4'h3, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 1, 4'h3, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'h3, 0);

        // Sole requester 2 holds for 20 cycles without preemption
        applyStimulus(0, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 2'd2, 1, 4'h3, 0);
        for (int i = 0; i < 19; i++)
            applyStimulus(0, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 2'd2, 1, 4'h3, 0);
        // Saturated hold: a new waiter forces release at the very next edge
        applyStimulus(0, 4'b0110, 4'b0000, 16'h0000, 4'b0000, 2'd2, 1, 4'h3, 0);
        applyStimulus(0, 4'b0010, 4'b0000, 16'h0000, 4'b0000, 2'd2, 0, 4'h3, 0);
        applyStimulus(0, 4'b0010, 4'b0000, 16'h0000, 4'b0010, 2'd1, 1, 4'h3, 0);

        // Reset during grant with owner writing 4'hF
        applyStimulus(1, 4'b0010, 4'b0010, 16'h00F0, 4'b0000, 2'd0, 0, 4'h0, 1);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'h0, 0);
        // Pointer was cleared by reset: 0 beats 3
        applyStimulus(0, 4'b1001, 4'b0000, 16'h0000, 4'b0001, 2'd0, 1, 4'h0, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 1, 4'h0, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'd0, 0, 4'h0, 0);

        // Pointer now 1 with requesters 0 and 1 both asking
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        applyStimulus(0, 4'b0011, 4'b0000, 16'h0000, 4'b0001, 2'd0, 1, 4'h0, 0);
        for (int i = 0; i < 30; i++)
            applyStimulus(0, 4'b0011, 4'b0000, 16'h0000, 4'b0001, 2'd0, 1, 4'h0, 0);
`else
        applyStimulus(0, 4'b0011, 4'b0000, 16'h0000, 4'b0010, 2'd1, 1, 4'h0, 0);
`endif

        // Let the monitor drain the scoreboard, bounded
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one internal WIDTH-bit enabled state register among NREQ requesters.
- A requester wins ownership and may write the register on any cycle it holds the grant.
- Ownership ends on voluntary release, or by timeout preemption when others are waiting.
- Sits between FSM-level control logic and the shared state storage of the structural FSM designs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, register width in bits
MAX_HOLD, 8, max consecutive grant cycles before preemption when another requester is waiting (>=2)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-high
req  in  NREQ  request/hold-ownership, one bit per requester
wr  in  NREQ  write strobe, one bit per requester
wdata  in  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot grant, registered
owner_id  out  $clog2(NREQ)  index of current/last owner
busy  out  1  high while in GRANT or RELEASE
reg_en  out  1  register write enable this cycle (combinational, observability)
q  out  WIDTH  shared register contents

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, owner_id=0, busy=0, q=0, rr pointer=0, hold counter=0. Reset mid-grant aborts immediately; no write lands on the reset edge.
- States:
  - IDLE: if any req, pick winner = first requester at or after the rr pointer (wrapping NREQ-1 -> 0). Next state GRANT, gnt[winner]=1, owner_id=winner, hold=0. If no req, stay.
  - GRANT: hold increments every cycle, saturating at MAX_HOLD-1.
    - Release when req[owner]=0: next state RELEASE.
    - Preempt when hold==MAX_HOLD-1 and any other req bit is high: next state RELEASE.
    - Sole requester is never preempted; it keeps the grant indefinitely.
  - RELEASE: exactly one cycle, gnt=0, no writes. On entering RELEASE, rr pointer = (owner_id+1) mod NREQ. Next state IDLE.
- Latency:
  - req sampled high in IDLE -> gnt high on the next cycle.
  - Minimum owner-to-owner handover: 3 cycles (GRANT -> RELEASE -> IDLE -> GRANT).
- Write path:
  - reg_en = (state==GRANT) & req[owner] & wr[owner].
  - q <= wdata slice of owner at the edge where reg_en=1; otherwise q holds.
  - wr from non-owners is ignored.
  - Write and release in the same cycle is impossible: release requires req[owner]=0, which gates reg_en.
- Preemption cycle: if the owner asserts wr on the cycle hold==MAX_HOLD-1, the write lands. The transition to RELEASE happens at the same edge.
- busy = (state != IDLE). owner_id holds its value through RELEASE and IDLE.
- Simultaneous requests in IDLE: round-robin order from the pointer; exactly one gnt bit ever set.

Optional Feature:
SHARED_REG_ARB_FIXED_PRIO_EN
- Defined: requester 0 wins every IDLE arbitration in which req[0]=1, ignoring the rr pointer. Requester 0 is never timeout-preempted. Other requesters use round-robin as usual.
- Undefined: pure round-robin for all requesters, as described above.

Decomposition:
- Package shared_reg_arbiter_pkg holds:
  - state enum {IDLE, GRANT, RELEASE} (2-bit);
  - function rr_pick(req, ptr) returning the winner index and valid flag.
- One sub-module, shared_reg_bank: WIDTH-bit register with clk, rst, en, d, q. Synchronous active-high reset to 0; loads d when en=1. It is instantiated once and driven by reg_en and the muxed wdata.

Test Plan:
- Reset, then req=4'b0001, wr=1, wdata slice0=4'hA -> gnt=0001 the cycle after req; q=4'hA one cycle after the grant is seen; owner_id=0, busy=1.
- req=4'b1010 simultaneous from IDLE, ptr=0 -> gnt=0010 first. Requester 1 drops req -> RELEASE (gnt=0) -> gnt=1000 three cycles after the drop; ptr then =0.
- Requester 2 holds req alone for 20 cycles -> gnt=0100 throughout, no preemption. Requester 0 raises req on cycle 5 of the grant -> requester 2 released after 8 total grant cycles; gnt=0001 2 cycles later.
- Non-owner wr: owner 1 wr=0 and requester 3 wr=1 with wdata=4'h5 -> reg_en=0, q unchanged.
- rst asserted during GRANT with owner wr=1, wdata=4'hF -> next cycle q=0, gnt=0, busy=0, owner_id=0.
- With SHARED_REG_ARB_FIXED_PRIO_EN: ptr=1, req=4'b0011 in IDLE -> gnt=0001. Requester 0 held 30 cycles with requester 1 waiting -> no preemption.
